// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages/fetch unit and pipe_ctrl.
// The master side is the pipeline; the slave side is the controller.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic [63:0] excp_target;
    logic        fetch_ack;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] new_pc;
    logic        new_pc_valid;
    logic        wdt_err;
    logic [31:0] perf_stall_id;
    logic [31:0] perf_stall_ex;
    logic [31:0] perf_stall_mem;
    logic [31:0] perf_flush;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_target, fetch_ack,
        input  stall, flush, new_pc, new_pc_valid, wdt_err,
        input  perf_stall_id, perf_stall_ex, perf_stall_mem, perf_flush
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_target, fetch_ack,
        output stall, flush, new_pc, new_pc_valid, wdt_err,
        output perf_stall_id, perf_stall_ex, perf_stall_mem, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, flush + held PC redirect, stall watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned WDT_CYCLES = 32'd1024
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam logic [31:0] LP_WDT = 32'(WDT_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc_q;
    logic [31:0] r_wdt_cnt;
    logic        r_wdt_err;

    logic [5:0]  w_req_mask;
    logic        w_redirect;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic [63:0] w_new_pc;
    logic        w_new_pc_valid;

    // Masks are nested, so OR-ing them lets the deepest requester dominate.
    assign w_req_mask = ({6{bus.stallreq_if}}  & 6'b000001)
                      | ({6{bus.stallreq_id}}  & 6'b000011)
                      | ({6{bus.stallreq_ex}}  & 6'b000111)
                      | ({6{bus.stallreq_mem}} & 6'b001111);

    assign w_redirect = (r_state == ST_REDIRECT);

    // Zero-latency control outputs; a flush overrides every stall request.
    always_comb begin
        w_stall        = 6'b000000;
        w_flush        = 1'b0;
        w_new_pc       = 64'd0;
        w_new_pc_valid = 1'b0;
        if (rst) begin
            w_stall        = 6'b000000;
            w_flush        = 1'b0;
            w_new_pc       = 64'd0;
            w_new_pc_valid = 1'b0;
        end else begin
            w_flush        = bus.excp_valid;
            w_new_pc_valid = bus.excp_valid | w_redirect;
            if (bus.excp_valid) begin
                w_stall  = 6'b000000;
                w_new_pc = bus.excp_target;
            end else if (w_redirect) begin
                w_stall  = w_req_mask | 6'b000001;
                w_new_pc = r_pc_q;
            end else begin
                w_stall  = w_req_mask;
                w_new_pc = 64'd0;
            end
        end
    end

    // Redirect FSM, latched target and stall watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc_q    <= 64'd0;
            r_wdt_cnt <= 32'd0;
            r_wdt_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.excp_valid && !bus.fetch_ack) begin
                        r_state <= ST_REDIRECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.fetch_ack) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_REDIRECT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (bus.excp_valid) begin
                r_pc_q <= bus.excp_target;
            end else begin
                r_pc_q <= r_pc_q;
            end

            // Counter saturates at the limit; the error flag is sticky until reset.
            if (w_stall != 6'b000000) begin
                if (r_wdt_cnt < LP_WDT) begin
                    r_wdt_cnt <= r_wdt_cnt + 32'd1;
                end else begin
                    r_wdt_cnt <= r_wdt_cnt;
                end
                if ((r_wdt_cnt + 32'd1) >= LP_WDT) begin
                    r_wdt_err <= 1'b1;
                end else begin
                    r_wdt_err <= r_wdt_err;
                end
            end else begin
                r_wdt_cnt <= 32'd0;
                r_wdt_err <= r_wdt_err;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.new_pc       = w_new_pc;
    assign bus.new_pc_valid = w_new_pc_valid;
    assign bus.wdt_err      = r_wdt_err & ~rst;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_id;
    logic [31:0] r_perf_stall_ex;
    logic [31:0] r_perf_stall_mem;
    logic [31:0] r_perf_flush;

    // Free-running wrap-around event counters keyed on the exact stall pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_id  <= 32'd0;
            r_perf_stall_ex  <= 32'd0;
            r_perf_stall_mem <= 32'd0;
            r_perf_flush     <= 32'd0;
        end else begin
            r_perf_stall_id  <= r_perf_stall_id  + ((w_stall == 6'b000011) ? 32'd1 : 32'd0);
            r_perf_stall_ex  <= r_perf_stall_ex  + ((w_stall == 6'b000111) ? 32'd1 : 32'd0);
            r_perf_stall_mem <= r_perf_stall_mem + ((w_stall == 6'b001111) ? 32'd1 : 32'd0);
            r_perf_flush     <= r_perf_flush     + (w_flush ? 32'd1 : 32'd0);
        end
    end

    assign bus.perf_stall_id  = rst ? 32'd0 : r_perf_stall_id;
    assign bus.perf_stall_ex  = rst ? 32'd0 : r_perf_stall_ex;
    assign bus.perf_stall_mem = rst ? 32'd0 : r_perf_stall_mem;
    assign bus.perf_flush     = rst ? 32'd0 : r_perf_flush;
`else
    assign bus.perf_stall_id  = 32'd0;
    assign bus.perf_stall_ex  = 32'd0;
    assign bus.perf_stall_mem = 32'd0;
    assign bus.perf_flush     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// redirect/watchdog/perf sequences, then random stimulus against a reference model.
module tb_pipe_ctrl;

    localparam int WDT = 8;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if u_if();

    pipe_ctrl #(.WDT_CYCLES(WDT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, expressed as "redirect pending" plus counts.
    bit          m_redir;
    logic [63:0] m_pc;
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_pid, m_pex, m_pmem, m_pfl;

    typedef struct {
        logic        r, sif, sid, sex, smem, ex;
        logic [63:0] tgt;
        logic        ack;
        logic [5:0]  st;
        logic        fl;
        logic [63:0] npc;
        logic        npcv;
        logic        wdt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic sif, input logic sid, input logic sex,
                         input logic smem, input logic ex, input logic [63:0] tgt, input logic ack);
        rst                = r;
        u_if.stallreq_if   = sif;
        u_if.stallreq_id   = sid;
        u_if.stallreq_ex   = sex;
        u_if.stallreq_mem  = smem;
        u_if.excp_valid    = ex;
        u_if.excp_target   = tgt;
        u_if.fetch_ack     = ack;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [5:0] st, input logic fl,
                              input logic [63:0] npc, input logic npcv, input logic wdt);
        chk({tag, ".stall"},        {58'd0, u_if.stall}, {58'd0, st});
        chk({tag, ".flush"},        {63'd0, u_if.flush}, {63'd0, fl});
        chk({tag, ".new_pc"},       u_if.new_pc, npc);
        chk({tag, ".new_pc_valid"}, {63'd0, u_if.new_pc_valid}, {63'd0, npcv});
        chk({tag, ".wdt_err"},      {63'd0, u_if.wdt_err}, {63'd0, wdt});
    endtask

    // Compare against the behavioural model, advance it, then move past the clock edge.
    task automatic model_step();
        int          depth;
        logic [5:0]  e_st;
        logic        e_fl, e_v;
        logic [63:0] e_pc;
        e_st = 6'd0; e_fl = 1'b0; e_v = 1'b0; e_pc = 64'd0;
        if (!rst) begin
            depth = u_if.stallreq_mem ? 4 : u_if.stallreq_ex ? 3 :
                    u_if.stallreq_id  ? 2 : u_if.stallreq_if ? 1 : 0;
            e_st = 6'((1 << depth) - 1);
            e_fl = u_if.excp_valid;
            if (e_fl) e_st = 6'd0;
            else if (m_redir) e_st[0] = 1'b1;
            e_v  = u_if.excp_valid || m_redir;
            e_pc = u_if.excp_valid ? u_if.excp_target : (m_redir ? m_pc : 64'd0);
        end
        chk("model.stall",        {58'd0, u_if.stall}, {58'd0, e_st});
        chk("model.flush",        {63'd0, u_if.flush}, {63'd0, e_fl});
        chk("model.new_pc",       u_if.new_pc, e_pc);
        chk("model.new_pc_valid", {63'd0, u_if.new_pc_valid}, {63'd0, e_v});
        chk("model.wdt_err",      {63'd0, u_if.wdt_err}, {63'd0, (m_err && !rst)});
        chk("model.perf_id",  {32'd0, u_if.perf_stall_id},  {32'd0, (PERF && !rst) ? m_pid  : 32'd0});
        chk("model.perf_ex",  {32'd0, u_if.perf_stall_ex},  {32'd0, (PERF && !rst) ? m_pex  : 32'd0});
        chk("model.perf_mem", {32'd0, u_if.perf_stall_mem}, {32'd0, (PERF && !rst) ? m_pmem : 32'd0});
        chk("model.perf_fl",  {32'd0, u_if.perf_flush},     {32'd0, (PERF && !rst) ? m_pfl  : 32'd0});
        if (rst) begin
            m_redir = 1'b0; m_pc = 64'd0; m_cnt = 0; m_err = 1'b0;
            m_pid = 32'd0; m_pex = 32'd0; m_pmem = 32'd0; m_pfl = 32'd0;
        end else begin
            if (u_if.excp_valid) m_pc = u_if.excp_target;
            m_redir = (u_if.excp_valid || m_redir) && !u_if.fetch_ack;
            if (e_st != 6'd0) m_cnt = (m_cnt < WDT) ? m_cnt + 1 : WDT;
            else m_cnt = 0;
            if (m_cnt >= WDT) m_err = 1'b1;
            if (e_st == 6'b000011) m_pid  = m_pid  + 32'd1;
            if (e_st == 6'b000111) m_pex  = m_pex  + 32'd1;
            if (e_st == 6'b001111) m_pmem = m_pmem + 32'd1;
            if (e_fl)              m_pfl  = m_pfl  + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] tgt;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h1234, 1'b0, 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 6'b000011, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 6'b001111, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 6'b000001, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0100, 1'b1, 6'b000000, 1'b1, 64'h8000_0100, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 6'b001111, 1'b0, 64'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hCAFE, 1'b1, 6'b000000, 1'b1, 64'hCAFE, 1'b1, 1'b0};

        m_redir = 1'b0; m_pc = 64'd0; m_cnt = 0; m_err = 1'b0;
        m_pid = 32'd0; m_pex = 32'd0; m_pmem = 32'd0; m_pfl = 32'd0;

        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].r, tbl[i].sif, tbl[i].sid, tbl[i].sex, tbl[i].smem,
                  tbl[i].ex, tbl[i].tgt, tbl[i].ack);
            expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].npc, tbl[i].npcv, tbl[i].wdt);
            model_step();
        end

        // Delayed ack: flush cycle, two plain waits, then the ack cycle.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0100, 1'b0);
        expect_out("dly.flush", 6'b000000, 1'b1, 64'h8000_0100, 1'b1, 1'b0);
        model_step();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, (i == 2));
            expect_out($sformatf("dly.wait%0d", i), 6'b000001, 1'b0, 64'h8000_0100, 1'b1, 1'b0);
            model_step();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        expect_out("dly.done", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();

        // Overwrite in REDIRECT, then reset abandons the redirect.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b0);
        model_step();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0200, 1'b0);
        expect_out("ovw.second", 6'b000000, 1'b1, 64'h8000_0200, 1'b1, 1'b0);
        model_step();
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0300, 1'b0);
        expect_out("ovw.rst", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        expect_out("ovw.idle", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();

        // Watchdog: 7 stalled cycles stay clean, 8 trip the sticky error.
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
            expect_out($sformatf("wdt7.c%0d", i), 6'b000111, 1'b0, 64'd0, 1'b0, 1'b0);
            model_step();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        expect_out("wdt7.drop", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
            expect_out($sformatf("wdt8.c%0d", i), 6'b000111, 1'b0, 64'd0, 1'b0, 1'b0);
            model_step();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
            expect_out($sformatf("wdt8.after%0d", i), 6'b000000, 1'b0, 64'd0, 1'b0, 1'b1);
            model_step();
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        expect_out("wdt.rst", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        expect_out("wdt.cleared", 6'b000000, 1'b0, 64'd0, 1'b0, 1'b0);
        model_step();

        // Perf: 5 EX stall cycles and 2 acknowledged exceptions after a reset.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        model_step();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
            model_step();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4000 + 64'(i), 1'b1);
            model_step();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("perf.stall_ex", {32'd0, u_if.perf_stall_ex}, PERF ? 64'd5 : 64'd0);
        chk("perf.flush",    {32'd0, u_if.perf_flush},    PERF ? 64'd2 : 64'd0);
        model_step();
`ifdef PIPE_CTRL_PERF_EN
        force dut.r_perf_stall_ex = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_stall_ex;
        m_pex = 32'hFFFF_FFFF;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("perf.preload", {32'd0, u_if.perf_stall_ex}, 64'hFFFF_FFFF);
        model_step();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("perf.wrap", {32'd0, u_if.perf_stall_ex}, 64'd0);
        model_step();
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tgt = {$urandom, $urandom};
            apply(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), tgt,
                  ($urandom_range(0, 2) == 0));
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
